// File: rtl/branch_redirect_unit.sv
// Branch resolve and redirect: evaluates the captured condition, then hands the target to IF over valid/ready.
// Optional BRANCH_STATS_EN adds stat_total / stat_taken resolution counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready for a branch request; capture on br_valid
// S_RESOLVE  | evaluate condition; not-taken resolves here, taken offers redirect
// S_REDIRECT | taken branch waiting for IF to accept the redirect
module branch_redirect_unit #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_type,
    input  logic              br_zero,
    input  logic              br_sign,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_offset,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_ifid,
    output logic              resolved,
`ifdef BRANCH_STATS_EN
    output logic [31:0]       stat_total,
    output logic [31:0]       stat_taken,
`endif
    output logic              taken
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RESOLVE  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        type_q, type_d;
    logic              zero_q, zero_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              done_q, done_d;

    logic              cond_taken;
    logic [ADDR_W-1:0] off_sext;
    logic [ADDR_W-1:0] target;

    always_comb begin
        cond_taken = 1'b0;
        case (type_q)
            3'd0:    cond_taken = zero_q;
            3'd1:    cond_taken = !zero_q;
            3'd2:    cond_taken = sign_q | zero_q;
            3'd3:    cond_taken = !sign_q & !zero_q;
            3'd4:    cond_taken = sign_q;
            3'd5:    cond_taken = !sign_q;
            3'd6:    cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    // Word offset: sign-extend, scale by 4, add to pc+4; wraps modulo 2^ADDR_W.
    always_comb begin
        off_sext = {{(ADDR_W-OFF_W){off_q[OFF_W-1]}}, off_q};
        target   = pc_q + ADDR_W'(4) + (off_sext << 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            type_q        <= '0;
            zero_q        <= 1'b0;
            sign_q        <= 1'b0;
            pc_q          <= '0;
            off_q         <= '0;
            redirect_pc_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            zero_q        <= zero_d;
            sign_q        <= sign_d;
            pc_q          <= pc_d;
            off_q         <= off_d;
            redirect_pc_q <= redirect_pc_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        zero_d        = zero_q;
        sign_d        = sign_q;
        pc_d          = pc_q;
        off_d         = off_q;
        redirect_pc_d = redirect_pc_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    type_d  = br_type;
                    zero_d  = br_zero;
                    sign_d  = br_sign;
                    pc_d    = br_pc;
                    off_d   = br_offset;
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (cond_taken) begin
                    redirect_pc_d = target;
                    // IF may accept on the very first valid cycle; that completes the redirect.
                    if (redirect_ready) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REDIRECT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        br_ready       = (state_q == S_IDLE);
        redirect_valid = ((state_q == S_RESOLVE) && cond_taken) || (state_q == S_REDIRECT);
        redirect_pc    = (state_q == S_RESOLVE) ? target : redirect_pc_q;
        flush_ifid     = done_q;
        taken          = done_q;
        resolved       = done_q || ((state_q == S_RESOLVE) && !cond_taken);
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_total_q, stat_total_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    always_comb begin
        stat_total_d = stat_total_q;
        stat_taken_d = stat_taken_q;
        if (resolved) begin
            stat_total_d = stat_total_q + 32'd1;
            if (taken) begin
                stat_taken_d = stat_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`endif

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
Consumer end of the branch-condition path. Accepts a branch request from the ID stage together with the zero/sign flags produced by the branch comparator. Resolves taken/not-taken and computes the target. For taken branches, drives a valid/ready redirect to the IF stage and pulses an IF/ID flush. Sits between the ID-stage comparator and the PC/fetch logic of the pipeline.

Parameters:
- ADDR_W, 32, PC/target width.
- OFF_W, 16, branch immediate width; sign-extended to ADDR_W.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  ID presents a branch request.
- br_ready  out  1  unit can accept a request.
- br_type  in  3  condition code (see Behaviour).
- br_zero  in  1  comparator result == 0 flag.
- br_sign  in  1  sign of comparator operand (src0[31]).
- br_pc  in  ADDR_W  PC of branch instruction.
- br_offset  in  OFF_W  word offset immediate.
- redirect_valid  out  1  redirect request to IF.
- redirect_ready  in  1  IF accepts redirect.
- redirect_pc  out  ADDR_W  new fetch address.
- flush_ifid  out  1  one-cycle IF/ID flush pulse.
- resolved  out  1  one-cycle pulse: a branch finished resolving (taken or not).
- taken  out  1  qualifies resolved; 1 = branch taken.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: state=IDLE, br_ready=1, redirect_valid=0, redirect_pc=0, flush_ifid=0, resolved=0, taken=0, captured registers=0.
- Reset mid-operation abandons any pending redirect. No flush is issued. The next cycle is IDLE.

FSM states and transitions:
- IDLE: br_ready=1. If br_valid, capture br_type/br_zero/br_sign/br_pc/br_offset and go to RESOLVE.
- RESOLVE: br_ready=0. Evaluate the condition on the captured flags.
  - Not taken: pulse resolved=1, taken=0, go to IDLE.
  - Taken: load redirect_pc, set redirect_valid=1, go to REDIRECT.
- REDIRECT: redirect_valid=1 and redirect_pc held stable until redirect_ready=1.
  - On handshake (redirect_valid & redirect_ready): next cycle redirect_valid=0, flush_ifid=1 for exactly one cycle, resolved=1, taken=1, go to IDLE.
  - redirect_ready asserted in the same cycle redirect_valid first rises is a valid handshake.

Condition codes (br_type):
- 0 BEQ: taken if zero.
- 1 BNE: taken if !zero.
- 2 BLEZ: taken if sign|zero.
- 3 BGTZ: taken if !sign&!zero.
- 4 BLTZ: taken if sign.
- 5 BGEZ: taken if !sign.
- 6 JUMP: always taken.
- 7 reserved: never taken, treated as not taken.

Target and latency:
- Target = br_pc + 4 + (sext(br_offset) << 2), computed modulo 2^ADDR_W (wrap-around, no overflow flag).
- Latency, acceptance to not-taken resolved pulse: 1 cycle.
- Latency, acceptance to redirect_valid: 1 cycle.
- flush_ifid: the cycle after the handshake.

Back-to-back and simultaneous events:
- A new br_valid may be accepted in the same cycle the unit returns to IDLE, since br_ready=1 whenever state==IDLE.
- br_valid while br_ready=0 is ignored. ID must hold the request.
- Captured inputs are not re-sampled after acceptance. Input changes during RESOLVE/REDIRECT have no effect.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: adds output ports stat_total (32) and stat_taken (32).
  - Both reset to 0.
  - stat_total increments on every resolved pulse.
  - stat_taken increments when resolved & taken.
  - Both wrap from 0xFFFFFFFF to 0.
- Not defined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles while br_valid=1 -> br_ready=1, redirect_valid=0, flush_ifid=0, resolved=0 throughout.
- BEQ taken: br_type=0, br_zero=1, br_pc=0x00400000, br_offset=0x0004, redirect_ready=1 -> redirect_valid 1 cycle after accept with redirect_pc=0x00400014; flush_ifid=1 one cycle later; resolved=1, taken=1.
- BNE not taken: br_type=1, br_zero=1 -> resolved=1, taken=0 one cycle after accept; no redirect_valid, no flush.
- Negative offset and back-pressure: br_type=6, br_pc=0x00000010, br_offset=0xFFFC, redirect_ready=0 for 3 cycles -> redirect_pc=0x00000004 held stable with redirect_valid=1 for 3 cycles. Then ready=1 -> single flush pulse.
- Wrap and back-to-back: br_pc=0xFFFFFFFC, br_offset=0x0001, BGEZ with sign=0 -> redirect_pc=0x00000004. A second request held valid is accepted in the first IDLE cycle. Asserting rst during REDIRECT -> redirect_valid drops next cycle, no flush.
- With BRANCH_STATS_EN: 3 taken + 2 not-taken branches -> stat_total=5, stat_taken=3. Preloading 0xFFFFFFFF wraps stat_total to 0.
